// File: rtl/cla_seq_adder_ctrl_if.sv
// Handshake and operand/result bundle for cla_seq_adder_ctrl.
// The sub select exists only when CLA_SUB_EN is defined.
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

`ifdef CLA_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`endif
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial adder: one 4-bit lookahead slice reused over WIDTH/4 steps, LSB first.
// Optional subtract mode is enabled by defining CLA_SUB_EN.
module carry_lookahead_4bits (
    output logic [3:0] s,
    output logic       cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    for (genvar gi = 0; gi < 4; gi++) begin : g_gp
        assign g[gi] = a[gi] & b[gi];
        assign p[gi] = a[gi] ^ b[gi];
        assign s[gi] = p[gi] ^ c[gi];
    end

    // Carries are flattened so every one depends only on g, p and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign cout = c[4];
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_seq_adder_ctrl_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             sa_reg;
    logic             sb_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [3:0]       slice_s;
    logic             slice_c;

`ifdef CLA_SUB_EN
    // Two's-complement subtraction: invert b and force the carry-in.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff = bus.b;
    assign c_eff = bus.cin;
`endif

    carry_lookahead_4bits u_slice (
        .s    (slice_s),
        .cout (slice_c),
        .a    (opa_reg[3:0]),
        .b    (opb_reg[3:0]),
        .cin  (carry_reg)
    );

    // New nibble enters at the top so the LSB nibble lands at bit 0 after NSLICE steps.
    always_comb begin
        sum_next = sum_reg >> 4;
        sum_next[WIDTH-1 -: 4] = slice_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            opa_reg       <= '0;
            opb_reg       <= '0;
            sum_reg       <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            sa_reg        <= 1'b0;
            sb_reg        <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa_reg      <= bus.a;
                        opb_reg      <= b_eff;
                        carry_reg    <= c_eff;
                        cnt_reg      <= '0;
                        sa_reg       <= bus.a[WIDTH-1];
                        sb_reg       <= b_eff[WIDTH-1];
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    opa_reg   <= opa_reg >> 4;
                    opb_reg   <= opb_reg >> 4;
                    carry_reg <= slice_c;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        cout_reg      <= slice_c;
                        ovf_reg       <= (sa_reg == sb_reg) && (slice_s[3] != sa_reg);
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomized and directed checks of cla_seq_adder_ctrl against an arithmetic reference model.
// Subtract scenarios are compiled in when CLA_SUB_EN is defined.
module tb_cla_seq_adder_ctrl;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef CLA_SUB_EN
    bit sub_sel = 1'b0;
    assign bus.sub = sub_sel;
`endif

    // Reference: plain integer addition of a, effective b and effective carry.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         output logic [WIDTH-1:0] es, output logic ec, output logic eo);
        logic [WIDTH-1:0] be;
        logic             ce;
        longint           u;
        longint           r;
        longint           maxv;
        longint           minv;
        be = b;
        ce = c;
`ifdef CLA_SUB_EN
        if (sub_sel) begin
            be = ~b;
            ce = 1'b1;
        end
`endif
        u    = longint'(a) + longint'(be) + longint'(ce);
        es   = u[WIDTH-1:0];
        ec   = u[WIDTH];
        r    = longint'($signed(a)) + longint'($signed(be)) + longint'(ce);
        maxv = (longint'(1) << (WIDTH - 1)) - 1;
        minv = -(longint'(1) << (WIDTH - 1));
        eo   = (r > maxv) || (r < minv);
    endtask

    // Issue one operation from IDLE, hold DONE for 'hold' cycles, then complete it.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input int hold, input string name);
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
        int               n;
        model(a, b, c, es, ec, eo);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: in_ready=%b want 1", name, bus.in_ready);
        end
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != NSLICE) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, n, NSLICE);
        end
        checks++;
        if (bus.sum !== es || bus.cout !== ec || bus.ovf !== eo) begin
            errors++;
            $display("FAIL %s result: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, bus.sum, bus.cout, bus.ovf, es, ec, eo);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_flags: in_ready=%b busy=%b want 0 1", name, bus.in_ready, bus.busy);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.sum !== es || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: out_valid=%b sum=%h in_ready=%b want 1 %h 0",
                         name, bus.out_valid, bus.sum, bus.in_ready, es);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.sum !== es || bus.cout !== ec || bus.ovf !== eo) begin
            errors++;
            $display("FAIL %s complete: in_ready=%b out_valid=%b busy=%b sum=%h want 1 0 0 %h",
                     name, bus.in_ready, bus.out_valid, bus.busy, bus.sum, es);
        end
        $display("op %s a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d hold=%0d",
                 name, a, b, c, bus.sum, bus.cout, bus.ovf, n, hold);
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: sum=%h cout=%b ovf=%b in_ready=%b out_valid=%b busy=%b want 0 0 0 1 0 0",
                     name, bus.sum, bus.cout, bus.ovf, bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        #12;
        check_idle_zero("reset_values");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("op reset released");
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b0, 0, "add_basic");
        checks++;
        if (bus.sum !== 16'h5555 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_basic_const: sum=%h cout=%b ovf=%b want 5555 0 0", bus.sum, bus.cout, bus.ovf);
        end
        run_op(16'hFFFF, 16'h0001, 1'b0, 1, "carry_chain");
        checks++;
        if (bus.sum !== 16'h0000 || bus.cout !== 1'b1 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_chain_const: sum=%h cout=%b ovf=%b want 0000 1 0", bus.sum, bus.cout, bus.ovf);
        end
        run_op(16'h7FFF, 16'h0000, 1'b1, 0, "signed_ovf");
        checks++;
        if (bus.sum !== 16'h8000 || bus.cout !== 1'b0 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL signed_ovf_const: sum=%h cout=%b ovf=%b want 8000 0 1", bus.sum, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.a = 16'h0001;
        bus.b = 16'h0002;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 16'h00AA;
        bus.b = 16'h0055;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != NSLICE || bus.sum !== 16'h0003) begin
            errors++;
            $display("FAIL bp_first: lat=%0d sum=%h want %0d 0003", n, bus.sum, NSLICE);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.sum !== 16'h0003 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: sum=%h in_ready=%b out_valid=%b want 0003 0 1",
                         bus.sum, bus.in_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sum !== 16'h0003) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b busy=%b sum=%h want 1 0 0003", bus.in_ready, bus.busy, bus.sum);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: busy=%b in_ready=%b want 1 0", bus.busy, bus.in_ready);
        end
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.sum !== 16'h00FF || n != NSLICE) begin
            errors++;
            $display("FAIL bp_second_result: sum=%h lat=%0d want 00ff %0d", bus.sum, n, NSLICE);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        $display("op backpressure a=0001 b=0002 then a=00aa b=0055 -> sum=%h", bus.sum);
    endtask

    task automatic test_reset_midrun();
        int seen;
        bus.a = 16'h1234;
        bus.b = 16'h1111;
        bus.cin = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_idle_zero("reset_midrun_async");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_result: out_valid seen %0d cycles want 0", seen);
        end
        $display("op reset mid-run aborted");
        run_op(16'($urandom), 16'($urandom), 1'($urandom), 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
`ifdef CLA_SUB_EN
            sub_sel = 1'($urandom);
`endif
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");
        end
`ifdef CLA_SUB_EN
        sub_sel = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
        int               n;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            model(a, b, c, es, ec, eo);
            bus.a = a;
            bus.b = b;
            bus.cin = c;
            bus.in_valid = 1'b1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: in_ready=%b want 1 right after completion", bus.in_ready);
            end
            @(posedge clk); #1;
            bus.a = ~a;
            bus.b = b ^ 16'h5A5A;
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != NSLICE || bus.sum !== es || bus.cout !== ec || bus.ovf !== eo) begin
                errors++;
                $display("FAIL b2b_result: lat=%0d sum=%h cout=%b ovf=%b want %0d %h %b %b",
                         n, bus.sum, bus.cout, bus.ovf, NSLICE, es, ec, eo);
            end
            $display("op back_to_back a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b",
                     a, b, c, bus.sum, bus.cout, bus.ovf);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

`ifdef CLA_SUB_EN
    task automatic test_sub();
        sub_sel = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, 0, "sub_neg");
        checks++;
        if (bus.sum !== 16'hFFFE || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_neg_const: sum=%h cout=%b ovf=%b want fffe 0 0", bus.sum, bus.cout, bus.ovf);
        end
        run_op(16'h8000, 16'h0001, 1'b0, 1, "sub_ovf");
        checks++;
        if (bus.sum !== 16'h7FFF || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf_const: sum=%h cout=%b ovf=%b want 7fff 1 1", bus.sum, bus.cout, bus.ovf);
        end
        run_op(16'h0009, 16'h0003, 1'b0, 0, "sub_cin_ignored");
        checks++;
        if (bus.sum !== 16'h0006 || bus.cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_cin_const: sum=%h cout=%b want 0006 1", bus.sum, bus.cout);
        end
        sub_sel = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
`ifdef CLA_SUB_EN
        test_sub();
`endif
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
